// File: rtl/calf_injector_pkg.sv
// Shared flit layout and sizing constants for the CALF injection stage.
package calf_injector_pkg;

  localparam int STEER_W     = 16;
  localparam int VALID_F     = 15;
  localparam int ADDR_N      = 16;
  localparam int DEST_W      = $clog2(ADDR_N);
  localparam int DEST_LO     = 0;
  localparam int CALF_QDEPTH = 4;
  localparam int NSLOT       = 4;

endpackage

// File: rtl/calf_inj_fifo.sv
// Injection FIFO: circular storage with wrapping read/write pointers and occupancy count.
module calf_inj_fifo
  import calf_injector_pkg::*;
#(
  parameter int QDEPTH = CALF_QDEPTH,
  parameter int W      = STEER_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [W-1:0]                din,
  input  logic                        pop,
  output logic [W-1:0]                dout,
  output logic [$clog2(QDEPTH+1)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  logic [W-1:0]  mem_q [QDEPTH];
  logic [W-1:0]  mem_d [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(QDEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/calf_injector.sv
// CALF local injection: drops the FIFO head into the lowest free slot and registers all slots.
module calf_injector
  import calf_injector_pkg::*;
#(
  parameter int QDEPTH     = CALF_QDEPTH,
  parameter int STARVE_LIM = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [STEER_W-1:0]          in_flit,
  output logic                        in_ready,
  input  logic [STEER_W-1:0]          c0,
  input  logic [STEER_W-1:0]          c1,
  input  logic [STEER_W-1:0]          c2,
  input  logic [STEER_W-1:0]          c3,
  output logic [STEER_W-1:0]          c0_o,
  output logic [STEER_W-1:0]          c1_o,
  output logic [STEER_W-1:0]          c2_o,
  output logic [STEER_W-1:0]          c3_o,
  output logic [$clog2(QDEPTH+1)-1:0] q_count,
  output logic                        starve
);

  localparam int SW = $clog2(STARVE_LIM+1);

  logic [STEER_W-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [STEER_W-1:0] slot_in [NSLOT];
  logic [STEER_W-1:0] slot_d  [NSLOT];
  logic [STEER_W-1:0] slot_q  [NSLOT];
  logic [SW-1:0]      cnt_d, cnt_q;
  logic               starve_d, starve_q;

  assign in_ready = rst_n & ~full;
  assign push     = in_valid & in_ready;

  calf_inj_fifo #(
    .QDEPTH (QDEPTH),
    .W      (STEER_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_flit),
    .pop   (pop),
    .dout  (head),
    .count (q_count),
    .full  (full),
    .empty (empty)
  );

  assign slot_in[0] = c0;
  assign slot_in[1] = c1;
  assign slot_in[2] = c2;
  assign slot_in[3] = c3;

  // Lowest-index free slot wins; every other slot passes through untouched.
  always_comb begin
    pop = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      slot_d[k] = slot_in[k];
    end
    for (int k = 0; k < NSLOT; k++) begin
      if (!empty && !pop && !slot_in[k][VALID_F]) begin
        slot_d[k]          = head;
        slot_d[k][VALID_F] = 1'b1;
        pop                = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pop || empty) begin
      cnt_d = '0;
    end else if (cnt_q != SW'(STARVE_LIM)) begin
      cnt_d = cnt_q + SW'(1);
    end
    starve_d = (cnt_d == SW'(STARVE_LIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSLOT; k++) begin
        slot_q[k] <= '0;
      end
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      for (int k = 0; k < NSLOT; k++) begin
        slot_q[k] <= slot_d[k];
      end
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  assign c0_o   = slot_q[0];
  assign c1_o   = slot_q[1];
  assign c2_o   = slot_q[2];
  assign c3_o   = slot_q[3];
  assign starve = starve_q;

endmodule

// File: doc/calf_injector.md
Name: calf_injector

Overview:
- Local-node injection stage directly downstream of the CALF ejector in the bufferless deflection router.
- Consumes the four post-ejection channel slots (c0..c3) and holds locally generated flits in a small FIFO.
- Inserts the FIFO head flit into the lowest-index empty slot, then registers all four slots toward the route/permute stage.
- Flags injection starvation for source throttling.

Parameters:
- QDEPTH, 4, injection FIFO depth in flits; power of two, minimum 2.
- STARVE_LIM, 8, consecutive blocked cycles before starve asserts; width = clog2(STARVE_LIM+1).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  local source presents a flit.
- in_flit  input  `steer_w  local flit; `dest_f is meaningful, `valid_f is ignored.
- in_ready  output  1  FIFO can accept; push occurs when in_valid && in_ready.
- c0, c1, c2, c3  input  `steer_w each  slots from the ejector; a slot is free when `valid_f == 0.
- c0_o, c1_o, c2_o, c3_o  output  `steer_w each  registered slots after injection.
- q_count  output  clog2(QDEPTH+1)  current FIFO occupancy.
- starve  output  1  head flit blocked STARVE_LIM consecutive cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - c*_o = 0, q_count = 0, starve = 0.
  - FIFO pointers and starve counter cleared; FIFO contents discarded.
  - in_ready is low while rst_n is low and high once released.
- Asserting rst_n mid-operation drops queued flits and any in-flight slot contents.
- FIFO:
  - in_ready = (q_count != QDEPTH), combinational from registered state only.
  - Push and pop may happen in the same cycle; q_count is then unchanged.
  - Read and write pointers wrap modulo QDEPTH.
- Injection decision (combinational, each cycle):
  - Requires q_count > 0.
  - free_k = ~ck[`valid_f].
  - Select the lowest k with free_k (priority c0 > c1 > c2 > c3).
  - The selected slot takes the head flit with `valid_f forced to 1. Head pops.
  - No free slot: no pop, head is retained.
- Non-selected slots pass through unchanged, including invalid slots carrying garbage; no slot is zeroed.
- Output register: c*_o load the merged slots at every rising clk edge; fixed 1-cycle latency.
- No bypass:
  - A flit pushed at edge E is the head after E.
  - Its earliest appearance is on cN_o after edge E+1.
  - It never appears in the same cycle it is presented.
- Order: strict FIFO; at most one flit injected per cycle.
- Starve counter:
  - Increments when the head is present and no slot is free.
  - Clears on a pop or when the FIFO is empty.
  - Saturates at STARVE_LIM.
  - starve is registered and equals (cnt == STARVE_LIM).
- A valid input slot is never overwritten or dropped; flit conservation holds.

Decomposition:
- Shared defines (existing defines.v): `steer_w, `valid_f, `dest_f, `addr_n. No new typedefs; optionally add `calf_qdepth there.
- One sub-module: calf_inj_fifo.
  - Ports: clk, rst_n, push, din, pop, dout, count, full, empty.
  - Holds the storage and pointers.
- Top level holds slot select, merge, output regs and starve counter.

Test Plan:
- Reset: drive rst_n=0 mid-stream with 3 flits queued -> immediately c*_o=0, q_count=0, starve=0; after release, in_ready=1.
- Basic inject: all cX valid except c2 (valid_f=0); push flit dest=5 at edge E -> at E+1, c2_o = that flit with valid_f=1; c0_o, c1_o, c3_o equal their inputs; q_count back to 0.
- Priority: c1 and c3 free, two flits queued (A, B) -> cycle 1: A lands in c1_o, c3_o passes through; next cycle with same slots: B lands in c1_o.
- Full/backpressure: all slots valid, push 4 flits -> q_count=4, in_ready=0. A 5th in_valid is not accepted. Free c0 for one cycle -> first flit appears on c0_o, in_ready=1 the following cycle.
- Starvation: 1 flit queued, all slots valid for 10 cycles -> starve rises after the 8th blocked cycle and holds. Free c3 -> flit injected, starve=0 next cycle.
- Simultaneous push/pop at q_count=2 with a free slot -> q_count stays 2, FIFO order preserved across pointer wrap (inject 8 flits with ids 0..7, observe 0..7 in order).
